calc_seq_core: RTL and testbench



---
 rtl/calc_seq_core.sv | 244 ++++++++++++++++++++++++
 tb/tb_calc_seq_core.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_seq_core.sv
// Push-switch calculator core: debounced key events drive a signed add/subtract
// sequencer whose signed-magnitude result is handed to the 7-segment controller.
module calc_seq_core #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned DEBOUNCE = 16
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic [13:0]      PSW,
    output logic [WIDTH-1:0] DISP_MAG,
    output logic             DISP_NEG,
    output logic             DISP_ERR,
    output logic             RES_VLD,
    output logic [2:0]       STATE
);

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam int unsigned MAXV = pow10(DIGITS) - 1;
    localparam int unsigned SW   = WIDTH + 2;
    localparam int unsigned MW   = WIDTH + 4;
    localparam int unsigned CW   = $clog2(DEBOUNCE + 1);

    typedef enum logic [2:0] {
        ST_ENT_A  = 3'd0,
        ST_OP     = 3'd1,
        ST_ENT_B  = 3'd2,
        ST_RESULT = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        KEY_NONE, KEY_CLR, KEY_EQ, KEY_MINUS, KEY_PLUS, KEY_DIGIT
    } key_e;

    logic [13:0] sync1_q, sync2_q, cand_q, stable_q, stable_prev_q, ev_c;
    logic [CW-1:0] cnt_q, run_c;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic             a_neg_q, a_neg_d, r_neg_q, r_neg_d, op_q, op_d;
    logic [WIDTH-1:0] disp_mag_q, disp_mag_d;
    logic             disp_neg_q, disp_neg_d, disp_err_q, disp_err_d;
    logic             res_vld_q, res_vld_d;

    key_e             key_c;
    logic [3:0]       dig_c;
    logic             is_op_c, key_sub_c;
    logic [MW-1:0]    a_app_c, b_app_c;
    logic             a_fits_c, b_fits_c;
    logic             calc_ovf_c, calc_neg_c;
    logic [WIDTH-1:0] calc_mag_c;

    // Number of consecutive cycles the synchronised vector has held, counting this one.
    always_comb begin
        if (sync2_q != cand_q)              run_c = CW'(1);
        else if (cnt_q == CW'(DEBOUNCE))    run_c = cnt_q;
        else                                run_c = cnt_q + CW'(1);
    end

    assign ev_c = stable_q & ~stable_prev_q;

    // Highest-priority event wins; the loop runs downward so the lowest digit sticks.
    always_comb begin
        key_c = KEY_NONE;
        dig_c = '0;
        for (int i = 9; i >= 0; i--) begin
            if (ev_c[i]) begin
                key_c = KEY_DIGIT;
                dig_c = 4'(i);
            end
        end
        if (ev_c[10]) key_c = KEY_PLUS;
        if (ev_c[11]) key_c = KEY_MINUS;
        if (ev_c[12]) key_c = KEY_EQ;
        if (ev_c[13]) key_c = KEY_CLR;
    end

    assign is_op_c   = (key_c == KEY_PLUS) || (key_c == KEY_MINUS);
    assign key_sub_c = (key_c == KEY_MINUS);
    assign a_app_c   = MW'(a_q) * MW'(10) + MW'(dig_c);
    assign b_app_c   = MW'(b_q) * MW'(10) + MW'(dig_c);
    assign a_fits_c  = (a_app_c <= MW'(MAXV));
    assign b_fits_c  = (b_app_c <= MW'(MAXV));

    // Signed-magnitude add/sub via two's complement; returns {overflow, neg, magnitude}.
    function automatic logic [WIDTH+1:0] calc(input logic x_neg, input logic [WIDTH-1:0] x_mag,
                                              input logic sub, input logic [WIDTH-1:0] y_mag);
        logic [SW-1:0] sx, sr, mag;
        sx  = x_neg ? (SW'(0) - SW'(x_mag)) : SW'(x_mag);
        sr  = sub ? (sx - SW'(y_mag)) : (sx + SW'(y_mag));
        mag = sr[SW-1] ? (SW'(0) - sr) : sr;
        return {(mag > SW'(MAXV)), sr[SW-1], mag[WIDTH-1:0]};
    endfunction

    // The left operand is R when repeating from RESULT, otherwise A.
    assign {calc_ovf_c, calc_neg_c, calc_mag_c} =
        (state_q == ST_RESULT) ? calc(r_neg_q, r_q, op_q, b_q) : calc(a_neg_q, a_q, op_q, b_q);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        a_neg_d   = a_neg_q;
        b_d       = b_q;
        r_d       = r_q;
        r_neg_d   = r_neg_q;
        op_d      = op_q;
        res_vld_d = 1'b0;
        if (key_c == KEY_CLR) begin
            state_d = ST_ENT_A;
            a_d     = '0;
            a_neg_d = 1'b0;
            b_d     = '0;
            r_d     = '0;
            r_neg_d = 1'b0;
            op_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ENT_A: begin
                    if (key_c == KEY_DIGIT && a_fits_c) begin
                        a_d = WIDTH'(a_app_c);
                    end else if (is_op_c) begin
                        op_d    = key_sub_c;
                        state_d = ST_OP;
                    end
                end
                ST_OP: begin
                    if (key_c == KEY_DIGIT) begin
                        b_d     = WIDTH'(dig_c);
                        state_d = ST_ENT_B;
                    end else if (is_op_c) begin
                        op_d = key_sub_c;
                    end
                end
                ST_ENT_B: begin
                    if (key_c == KEY_DIGIT && b_fits_c) begin
                        b_d = WIDTH'(b_app_c);
                    end else if (key_c == KEY_EQ || is_op_c) begin
                        if (calc_ovf_c) begin
                            state_d = ST_ERROR;
                        end else begin
                            r_d       = calc_mag_c;
                            r_neg_d   = calc_neg_c;
                            res_vld_d = 1'b1;
                            if (key_c == KEY_EQ) begin
                                state_d = ST_RESULT;
                            end else begin
                                a_d     = calc_mag_c;
                                a_neg_d = calc_neg_c;
                                op_d    = key_sub_c;
                                state_d = ST_OP;
                            end
                        end
                    end
                end
                ST_RESULT: begin
                    if (is_op_c) begin
                        a_d     = r_q;
                        a_neg_d = r_neg_q;
                        op_d    = key_sub_c;
                        state_d = ST_OP;
                    end else if (key_c == KEY_DIGIT) begin
                        a_d     = WIDTH'(dig_c);
                        a_neg_d = 1'b0;
                        state_d = ST_ENT_A;
                    end else if (key_c == KEY_EQ) begin
                        if (calc_ovf_c) begin
                            state_d = ST_ERROR;
                        end else begin
                            a_d       = r_q;
                            a_neg_d   = r_neg_q;
                            r_d       = calc_mag_c;
                            r_neg_d   = calc_neg_c;
                            res_vld_d = 1'b1;
                        end
                    end
                end
                ST_ERROR: ;
                default:  state_d = ST_ENT_A;
            endcase
        end

        disp_err_d = (state_d == ST_ERROR);
        case (state_d)
            ST_ENT_A, ST_OP: begin disp_mag_d = a_d; disp_neg_d = a_neg_d; end
            ST_ENT_B:        begin disp_mag_d = b_d; disp_neg_d = 1'b0;    end
            ST_RESULT:       begin disp_mag_d = r_d; disp_neg_d = r_neg_d; end
            default:         begin disp_mag_d = '0;  disp_neg_d = 1'b0;    end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            cand_q        <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            cnt_q         <= '0;
            state_q       <= ST_ENT_A;
            a_q           <= '0;
            a_neg_q       <= 1'b0;
            b_q           <= '0;
            r_q           <= '0;
            r_neg_q       <= 1'b0;
            op_q          <= 1'b0;
            disp_mag_q    <= '0;
            disp_neg_q    <= 1'b0;
            disp_err_q    <= 1'b0;
            res_vld_q     <= 1'b0;
        end else begin
            sync1_q       <= PSW;
            sync2_q       <= sync1_q;
            cand_q        <= sync2_q;
            cnt_q         <= run_c;
            if (run_c == CW'(DEBOUNCE)) stable_q <= sync2_q;
            stable_prev_q <= stable_q;
            state_q       <= state_d;
            a_q           <= a_d;
            a_neg_q       <= a_neg_d;
            b_q           <= b_d;
            r_q           <= r_d;
            r_neg_q       <= r_neg_d;
            op_q          <= op_d;
            disp_mag_q    <= disp_mag_d;
            disp_neg_q    <= disp_neg_d;
            disp_err_q    <= disp_err_d;
            res_vld_q     <= res_vld_d;
        end
    end

    assign DISP_MAG = disp_mag_q;
    assign DISP_NEG = disp_neg_q;
    assign DISP_ERR = disp_err_q;
    assign RES_VLD  = res_vld_q;
    assign STATE    = state_q;

endmodule

// File: tb/tb_calc_seq_core.sv
// Bench for calc_seq_core: key presses feed an arithmetic reference model whose
// predicted display changes are queued and matched by an independent monitor.
module tb_calc_seq_core;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned DEBOUNCE = 2;
    localparam int          MAXV     = 99;
    localparam int          LAT      = DEBOUNCE + 3;

    logic             CLK = 1'b0;
    logic             RST_X;
    logic [13:0]      PSW;
    logic [WIDTH-1:0] DISP_MAG;
    logic             DISP_NEG, DISP_ERR, RES_VLD;
    logic [2:0]       STATE;

    calc_seq_core #(.WIDTH(WIDTH), .DIGITS(2), .DEBOUNCE(DEBOUNCE)) dut (
        .CLK(CLK), .RST_X(RST_X), .PSW(PSW), .DISP_MAG(DISP_MAG), .DISP_NEG(DISP_NEG),
        .DISP_ERR(DISP_ERR), .RES_VLD(RES_VLD), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0]  mag;
        logic        neg;
        logic        err;
        logic        vld;
        logic [2:0]  st;
        logic [31:0] cyc;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: calculator state kept as plain signed integers.
    int m_st, m_a, m_b, m_r, m_op;
    int pm_mag, pm_neg, pm_err, pm_st;

    function automatic obs_t mk(input int mag, input int neg, input int err, input int vld,
                                input int st, input int c);
        obs_t o;
        o.mag = 8'(mag); o.neg = 1'(neg); o.err = 1'(err); o.vld = 1'(vld);
        o.st  = 3'(st);  o.cyc = 32'(c);
        return o;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_a = 0; m_b = 0; m_r = 0; m_op = 0;
        pm_mag = 0; pm_neg = 0; pm_err = 0; pm_st = 0;
    endtask

    task automatic model_key(input logic [13:0] m, output bit pulse);
        int res, d, mag, lhs;
        pulse = 1'b0;
        if (m[13]) begin
            m_st = 0; m_a = 0; m_b = 0; m_r = 0; m_op = 0;
        end else if (m_st == 4) begin
        end else if (m[12]) begin
            if (m_st == 2 || m_st == 3) begin
                lhs = (m_st == 3) ? m_r : m_a;
                res = m_op ? lhs - m_b : lhs + m_b;
                if (iabs(res) > MAXV) m_st = 4;
                else begin
                    m_a = lhs; m_r = res; m_st = 3; pulse = 1'b1;
                end
            end
        end else if (m[11] || m[10]) begin
            case (m_st)
                0: begin m_op = int'(m[11]); m_st = 1; end
                1: m_op = int'(m[11]);
                2: begin
                    res = m_op ? m_a - m_b : m_a + m_b;
                    if (iabs(res) > MAXV) m_st = 4;
                    else begin
                        m_r = res; m_a = res; m_op = int'(m[11]); m_st = 1; pulse = 1'b1;
                    end
                end
                default: begin m_a = m_r; m_op = int'(m[11]); m_st = 1; end
            endcase
        end else begin
            d = -1;
            for (int i = 9; i >= 0; i--) if (m[i]) d = i;
            if (d >= 0) begin
                case (m_st)
                    0: begin
                        mag = iabs(m_a) * 10 + d;
                        if (mag <= MAXV) m_a = (m_a < 0) ? -mag : mag;
                    end
                    1: begin m_b = d; m_st = 2; end
                    2: if (m_b * 10 + d <= MAXV) m_b = m_b * 10 + d;
                    default: begin m_a = d; m_st = 0; end
                endcase
            end
        end
    endtask

    task automatic model_disp(output int mag, output int neg, output int err);
        err = 0;
        case (m_st)
            0, 1:    begin mag = iabs(m_a); neg = int'(m_a < 0); end
            2:       begin mag = m_b;       neg = 0;             end
            3:       begin mag = iabs(m_r); neg = int'(m_r < 0); end
            default: begin mag = 0;         neg = 0; err = 1;    end
        endcase
    endtask

    // Apply the key to the model at press time and queue the predicted display changes.
    task automatic predict(input logic [13:0] m, input int t);
        bit pulse;
        int mag, neg, err;
        model_key(m, pulse);
        model_disp(mag, neg, err);
        if (pulse) begin
            exp_q.push_back(mk(mag, neg, err, 1, m_st, t + LAT));
            exp_q.push_back(mk(mag, neg, err, 0, m_st, t + LAT + 1));
        end else if (mag != pm_mag || neg != pm_neg || err != pm_err || m_st != pm_st) begin
            exp_q.push_back(mk(mag, neg, err, 0, m_st, t + LAT));
        end
        pm_mag = mag; pm_neg = neg; pm_err = err; pm_st = m_st;
    endtask

    task automatic press(input logic [13:0] m);
        @(posedge CLK); #1;
        PSW = m;
        predict(m, cyc);
        repeat (DEBOUNCE + 4) @(posedge CLK);
        #1 PSW = '0;
        repeat (DEBOUNCE + 6) @(posedge CLK);
    endtask

    function automatic logic [13:0] keymask(input byte c);
        if (c >= 8'd48 && c <= 8'd57) return 14'd1 << (c - 8'd48);
        if (c == "+") return 14'h0400;
        if (c == "-") return 14'h0800;
        if (c == "=") return 14'h1000;
        return 14'h2000;
    endfunction

    task automatic press_str(input string s);
        for (int i = 0; i < s.len(); i++) press(keymask(s[i]));
    endtask

    // Monitor: every visible output change must match the head of the expectation queue.
    logic [13:0] prev_out = '0;
    always @(negedge CLK) begin
        obs_t cur, e;
        cur = mk(int'(DISP_MAG), int'(DISP_NEG), int'(DISP_ERR), int'(RES_VLD), int'(STATE), cyc);
        if (!RST_X) begin
            prev_out = '0;
        end else if (cur[45:32] != prev_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change: got mag=%0d neg=%0d err=%0d vld=%0d st=%0d at cyc=%0d, none expected",
                         cur.mag, cur.neg, cur.err, cur.vld, cur.st, cur.cyc);
            end else begin
                e = exp_q.pop_front();
                if (cur != e) begin
                    failures++;
                    $display("FAIL scoreboard: got mag=%0d neg=%0d err=%0d vld=%0d st=%0d cyc=%0d, want mag=%0d neg=%0d err=%0d vld=%0d st=%0d cyc=%0d",
                             cur.mag, cur.neg, cur.err, cur.vld, cur.st, cur.cyc,
                             e.mag, e.neg, e.err, e.vld, e.st, e.cyc);
                end
            end
            prev_out = cur[45:32];
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if (DISP_MAG != '0 || DISP_NEG || DISP_ERR || RES_VLD || STATE != 3'd0) begin
            failures++;
            $display("FAIL %s: got mag=%0d neg=%0d err=%0d vld=%0d st=%0d, want all 0",
                     name, DISP_MAG, DISP_NEG, DISP_ERR, RES_VLD, STATE);
        end
    endtask

    initial begin
        logic [13:0] m;
        int r;
        RST_X = 1'b0;
        PSW   = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1 check_zero("reset_state");
        RST_X = 1'b1;

        press_str("47+5=C12-30=+5==C99+9=3C999");

        // One-cycle glitch must not register.
        @(posedge CLK); #1 PSW = 14'h0020;
        @(posedge CLK); #1 PSW = '0;
        repeat (10) @(posedge CLK);

        press_str("C1+2");
        press(14'h2008);
        press(14'h0404);

        // Mid-operation reset, with a digit held through release.
        press_str("C3+4");
        @(posedge CLK); #1 RST_X = 1'b0;
        PSW = 14'h0040;
        #1 check_zero("async_reset");
        exp_q.delete();
        model_reset();
        @(posedge CLK); #1 RST_X = 1'b1;
        predict(14'h0040, cyc);
        repeat (DEBOUNCE + 6) @(posedge CLK);
        #1 PSW = '0;
        repeat (DEBOUNCE + 6) @(posedge CLK);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      m = 14'd1 << $urandom_range(0, 9);
            else if (r < 70) m = 14'h0400;
            else if (r < 78) m = 14'h0800;
            else if (r < 92) m = 14'h1000;
            else             m = 14'h2000;
            if ($urandom_range(0, 9) == 0) m = m | (14'd1 << $urandom_range(0, 13));
            press(m);
        end

        repeat (20) @(posedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
